// File: rtl/apb4_pkg.sv
// Shared APB4 definitions: requester FSM state encoding and response codes.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic APB_RESP_OKAY   = 1'b0;
  localparam logic APB_RESP_SLVERR = 1'b1;

  localparam int unsigned APB_DATA_W = 32;
  localparam int unsigned APB_STRB_W = 4;

  // Maps the slave's pslverr pin onto the response-code space.
  function automatic logic apb_resp_code(input logic slverr);
    return slverr ? APB_RESP_SLVERR : APB_RESP_OKAY;
  endfunction

endpackage

// File: rtl/apb4_timeout_cnt.sv
// Saturating wait-state counter with a terminal-count flag at TIMEOUT_CYC-1.
module apb4_timeout_cnt #(
  parameter int TIMEOUT_WD  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TIMEOUT_WD-1:0] TC_VAL  = TIMEOUT_WD'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_WD-1:0] CNT_MAX = {TIMEOUT_WD{1'b1}};

  logic [TIMEOUT_WD-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + TIMEOUT_WD'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/apb4_cmd_master.sv
// APB4 requester: one command in over valid/ready, SETUP/ACCESS sequencing with a
// wait-state timeout, one response out over valid/ready. All outputs are registered.
module apb4_cmd_master
  import apb4_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int TIMEOUT_WD  = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRWIDTH-1:0]  cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDRWIDTH-1:0]  paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDRWIDTH-1:0]  paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic cnt_clr;
  logic cnt_en;
  logic cnt_tc;

  // The handshake uses the registered cmd_ready so the requester sees exactly what we sample.
  assign accept  = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign cnt_clr = (state_q == ST_SETUP);
  assign cnt_en  = (state_q == ST_ACCESS) && !pready;

  apb4_timeout_cnt #(
    .TIMEOUT_WD  (TIMEOUT_WD),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk (pclk),
    .rst (preset),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept)            state_d = ST_SETUP;
      ST_SETUP:                         state_d = ST_ACCESS;
      ST_ACCESS: if (pready || cnt_tc)  state_d = ST_RESP;
      ST_RESP:   if (rsp_ready)         state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          // Reads never expose stale write data or strobes on the bus.
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb  : '0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = apb_resp_code(pslverr);
          rsp_timeout_d = 1'b0;
        end else if (cnt_tc) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = APB_RESP_SLVERR;
          rsp_timeout_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Self-checking bench for apb4_cmd_master: scripted slave plus a response scoreboard.
module tb_apb4_cmd_master;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb4_cmd_master #(
    .ADDRWIDTH   (12),
    .TIMEOUT_WD  (8),
    .TIMEOUT_CYC (4)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Scripted slave: pready after slv_wait ACCESS cycles unless hung.
  int          slv_wait  = 0;
  logic        slv_hang  = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt;

  assign pready  = psel && penable && !slv_hang && (acc_cnt >= slv_wait);
  assign pslverr = slv_err && pready;
  assign prdata  = slv_rdata;

  always @(posedge pclk or posedge preset) begin
    if (preset)                        acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                               acc_cnt <= 0;
  end

  // Scoreboard: every response handshake must match the oldest expected entry.
  always @(negedge pclk) begin
    if (!preset && rsp_valid && rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rsp: got rdata=%h err=%b to=%b, none expected",
                 rsp_rdata, rsp_err, rsp_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {mon_e.rdata, mon_e.err, mon_e.to})
          $display("FAIL rsp_scoreboard: got rdata=%h err=%b to=%b, want rdata=%h err=%b to=%b",
                   rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.to);
        else
          n_pass++;
      end
    end
  end

  // Presents a command and returns once it is accepted (ok=0 if never accepted).
  task automatic do_cmd(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic ok);
    logic rdy;
    ok        = 1'b0;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = cmd_ready;
      @(posedge pclk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite,
         paddr, pwdata, pstrb} !== '0)
      $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b psel=%b penable=%b paddr=%h pwdata=%h, want all 0",
               cmd_ready, rsp_valid, psel, penable, paddr, pwdata);
    else n_pass++;
    preset = 1'b0;
    @(posedge pclk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_zero_wait();
    logic ok;
    slv_wait = 0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    do_cmd(1'b1, 12'h004, 32'hA5A5_0001, 4'hF, ok);
    n_checks++;
    if (!ok || psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 || paddr !== 12'h004 ||
        pwdata !== 32'hA5A5_0001 || pstrb !== 4'hF)
      $display("FAIL wr_setup: ok=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h, want 1 1 0 1 004 a5a50001 f",
               ok, psel, penable, pwrite, paddr, pwdata, pstrb);
    else n_pass++;
    @(posedge pclk); #1;
    n_checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 1'b0)
      $display("FAIL wr_access: psel=%b penable=%b rsp_valid=%b, want 1 1 0", psel, penable, rsp_valid);
    else n_pass++;
    @(posedge pclk); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || psel !== 1'b0 || penable !== 1'b0)
      $display("FAIL wr_rsp: rsp_valid=%b psel=%b penable=%b, want 1 0 0", rsp_valid, psel, penable);
    else n_pass++;
    @(posedge pclk); #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL wr_idle: rsp_valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready);
    else n_pass++;
  endtask

  // Three wait states: pready arrives in the 4th ACCESS cycle, which is also the
  // timeout terminal cycle for TIMEOUT_CYC=4, so completion must win.
  task automatic test_read_wait();
    logic ok;
    slv_wait  = 3;
    slv_rdata = 32'hDEAD_BEEF;
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0, to: 1'b0});
    do_cmd(1'b0, 12'h010, 32'hFFFF_FFFF, 4'hF, ok);
    n_checks++;
    if (!ok || pwrite !== 1'b0 || pstrb !== 4'h0 || pwdata !== 32'h0 || paddr !== 12'h010)
      $display("FAIL rd_setup: ok=%b pwrite=%b pstrb=%h pwdata=%h paddr=%h, want 1 0 0 0 010",
               ok, pwrite, pstrb, pwdata, paddr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      n_checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 12'h010 || pstrb !== 4'h0 || rsp_valid !== 1'b0)
        $display("FAIL rd_access_%0d: psel=%b penable=%b paddr=%h pstrb=%h rsp_valid=%b, want 1 1 010 0 0",
                 i, psel, penable, paddr, pstrb, rsp_valid);
      else n_pass++;
    end
    @(posedge pclk); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || psel !== 1'b0 || rsp_timeout !== 1'b0)
      $display("FAIL rd_rsp: rsp_valid=%b psel=%b rsp_timeout=%b, want 1 0 0", rsp_valid, psel, rsp_timeout);
    else n_pass++;
    slv_wait = 0;
  endtask

  task automatic test_slave_error();
    logic ok;
    slv_wait  = 1;
    slv_err   = 1'b1;
    slv_rdata = 32'h1234_5678;
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b1, to: 1'b0});
    do_cmd(1'b0, 12'h024, 32'h0, 4'h0, ok);
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
      @(posedge pclk); #1;
    end
    n_checks++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0)
      $display("FAIL slverr: ok=%b rsp_valid=%b rsp_err=%b rsp_timeout=%b, want 1 1 1 0",
               ok, rsp_valid, rsp_err, rsp_timeout);
    else n_pass++;
    @(posedge pclk); #1;
    slv_err  = 1'b0;
    slv_wait = 0;
  endtask

  task automatic test_timeout();
    logic ok;
    int   n_acc;
    slv_hang  = 1'b1;
    slv_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1, to: 1'b1});
    do_cmd(1'b0, 12'h030, 32'h0, 4'h0, ok);
    @(posedge pclk); #1;
    n_acc = 0;
    for (int i = 0; i < 20 && psel === 1'b1 && penable === 1'b1; i++) begin
      n_acc++;
      @(posedge pclk); #1;
    end
    n_checks++;
    if (!ok || n_acc != 4 || rsp_valid !== 1'b1 || psel !== 1'b0 || rsp_timeout !== 1'b1)
      $display("FAIL timeout: ok=%b access_cycles=%0d rsp_valid=%b psel=%b rsp_timeout=%b, want 1 4 1 0 1",
               ok, n_acc, rsp_valid, psel, rsp_timeout);
    else n_pass++;
    @(posedge pclk); #1;
    slv_hang = 1'b0;
  endtask

  task automatic test_backpressure();
    logic        ok;
    logic [33:0] held;
    rsp_ready = 1'b0;
    slv_rdata = 32'h5555_AAAA;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, to: 1'b0});
    do_cmd(1'b1, 12'h040, 32'h0000_00FF, 4'h1, ok);
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
      @(posedge pclk); #1;
    end
    held = {rsp_rdata, rsp_err, rsp_timeout};
    slv_rdata = 32'h0BAD_F00D;
    exp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
    cmd_write = 1'b0;
    cmd_addr  = 12'h020;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge pclk); #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || {rsp_rdata, rsp_err, rsp_timeout} !== held)
        $display("FAIL bp_hold_%0d: cmd_ready=%b rsp_valid=%b rsp=%h, want 0 1 %h",
                 i, cmd_ready, rsp_valid, {rsp_rdata, rsp_err, rsp_timeout}, held);
      else n_pass++;
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0)
      $display("FAIL bp_release: cmd_ready=%b rsp_valid=%b psel=%b, want 1 0 0", cmd_ready, rsp_valid, psel);
    else n_pass++;
    @(posedge pclk); #1;
    n_checks++;
    if (psel !== 1'b1 || cmd_ready !== 1'b0 || paddr !== 12'h020 || pwrite !== 1'b0)
      $display("FAIL bp_next_accept: psel=%b cmd_ready=%b paddr=%h pwrite=%b, want 1 0 020 0",
               psel, cmd_ready, paddr, pwrite);
    else n_pass++;
    cmd_valid = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge pclk); #1;
    end
    n_checks++;
    if (!ok || exp_q.size() != 0)
      $display("FAIL bp_drain: ok=%b pending=%0d, want 1 0", ok, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    logic ok;
    slv_hang = 1'b1;
    do_cmd(1'b1, 12'h050, 32'h1111_2222, 4'h3, ok);
    @(posedge pclk); #1;
    n_checks++;
    if (!ok || psel !== 1'b1 || penable !== 1'b1)
      $display("FAIL rst_pre_access: ok=%b psel=%b penable=%b, want 1 1 1", ok, psel, penable);
    else n_pass++;
    #2 preset = 1'b1;
    #1;
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL rst_async: psel=%b penable=%b rsp_valid=%b cmd_ready=%b, want 0 0 0 0",
               psel, penable, rsp_valid, cmd_ready);
    else n_pass++;
    @(posedge pclk); #1;
    preset   = 1'b0;
    slv_hang = 1'b0;
    exp_q.delete();
    @(posedge pclk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(posedge pclk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || psel !== 1'b0)
        $display("FAIL rst_no_stale_%0d: rsp_valid=%b psel=%b, want 0 0", i, rsp_valid, psel);
      else n_pass++;
    end
  endtask

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_drain: pending=%0d want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
